// File: rtl/swap_cmd_sequencer.sv
// Command sequencer for the register-file swap unit.
// Queues host write/read/swap commands and issues them one at a time.
module swap_cmd_sequencer #(
    parameter int N           = 3,
    parameter int BITS        = 8,
    parameter int DEPTH       = 4,
    parameter int SWAP_CYCLES = 3
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [1:0]               cmd_op,
    input  logic [N-1:0]             cmd_a,
    input  logic [N-1:0]             cmd_b,
    input  logic [BITS-1:0]          cmd_data,
    output logic                     swap,
    output logic                     w_en,
    output logic [N-1:0]             w_addr,
    output logic [BITS-1:0]          w_data,
    output logic [N-1:0]             r_addr,
    output logic [N-1:0]             A_addr,
    output logic [N-1:0]             B_addr,
    input  logic [BITS-1:0]          r_data,
    output logic                     rd_valid,
    output logic [BITS-1:0]          rd_data,
    output logic                     err,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int WW = $clog2(SWAP_CYCLES + 1);

    typedef struct packed {
        logic [1:0]      op;
        logic [N-1:0]    a;
        logic [N-1:0]    b;
        logic [BITS-1:0] data;
    } cmd_t;

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        SWP,
        WAIT
    } state_t;

    cmd_t          mem [DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    state_t        state;
    logic [WW-1:0] wait_cnt;

    assign cmd_ready = (count != (AW + 1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{op: cmd_op, a: cmd_a, b: cmd_b, data: cmd_data};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Outputs are registered; address/data regs only move when a command loads.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            swap     <= 1'b0;
            w_en     <= 1'b0;
            w_addr   <= '0;
            w_data   <= '0;
            r_addr   <= '0;
            A_addr   <= '0;
            B_addr   <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            err      <= 1'b0;
        end else begin
            swap     <= 1'b0;
            w_en     <= 1'b0;
            rd_valid <= 1'b0;
            err      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pop) begin
                        unique case (head.op)
                            2'b00: begin
                                w_en   <= 1'b1;
                                w_addr <= head.a;
                                w_data <= head.data;
                                state  <= WR;
                            end
                            2'b01: begin
                                r_addr <= head.a;
                                state  <= RD;
                            end
                            2'b10: begin
                                if (head.a != '0 && head.b != '0) begin
                                    swap   <= 1'b1;
                                    A_addr <= head.a;
                                    B_addr <= head.b;
                                    state  <= SWP;
                                end else begin
                                    err <= 1'b1;
                                end
                            end
                            default: err <= 1'b1;
                        endcase
                    end
                end
                WR: state <= IDLE;
                RD: begin
                    rd_data  <= r_data;
                    rd_valid <= 1'b1;
                    state    <= IDLE;
                end
                SWP: begin
                    wait_cnt <= WW'(SWAP_CYCLES);
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - WW'(1);
                    if (wait_cnt == WW'(1)) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
